// File: rtl/demultiplexer_sync_if.sv
// Bus bundle for the 1-to-2 demultiplexer: one valid/ready input, two valid/ready outputs.
// The demux takes the slave modport and its driver takes the master modport.
interface demultiplexer_sync_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             ctrl;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out2;
    logic             out2_valid;
    logic             out2_ready;
    logic [CW-1:0]    cnt1;
    logic [CW-1:0]    cnt2;

    modport slave (
        input  in, in_valid, ctrl, out1_ready, out2_ready,
        output in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2
    );

    modport master (
        output in, in_valid, ctrl, out1_ready, out2_ready,
        input  in_ready, out1, out1_valid, out2, out2_valid, cnt1, cnt2
    );
endinterface

// File: rtl/demultiplexer_sync.sv
// Synchronous 1-to-2 demultiplexer: routes each accepted word by ctrl into one of
// two independent circular-buffer FIFOs, each drained through its own valid/ready port.
module demultiplexer_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             rdy,
    output logic [WIDTH-1:0] dout,
    output logic             dvalid,
    output logic [CW-1:0]    cnt,
    output logic             full
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wptr, rptr;
    logic [CW-1:0]               cnt_q, cnt_nxt;
    logic                        full_q;
    logic                        do_push, do_pop;

    // A full FIFO refuses the push even when a pop happens in the same edge (no bypass).
    assign do_push = push & ~full_q;
    assign do_pop  = rdy & (cnt_q != '0);

    always_comb begin
        cnt_nxt = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_nxt = cnt_q + CW'(1);
            2'b01:   cnt_nxt = cnt_q - CW'(1);
            default: cnt_nxt = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            cnt_q  <= cnt_nxt;
            full_q <= (cnt_nxt == CW'(DEPTH));
        end
    end

    // Storage carries no reset; the empty mask on dout hides stale contents.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wptr] <= din;
    end

    assign dvalid = (cnt_q != '0);
    assign dout   = dvalid ? mem[rptr] : '0;
    assign cnt    = cnt_q;
    assign full   = full_q;
endmodule

module demultiplexer_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demultiplexer_sync_if.slave   bus
);
    localparam int NCH = 2;

    logic [NCH-1:0]            push, rdy, dvalid, full;
    logic [NCH-1:0][WIDTH-1:0] dout;
    logic [NCH-1:0][CW-1:0]    cnt;

    assign push = {bus.in_valid & bus.ctrl, bus.in_valid & ~bus.ctrl};
    assign rdy  = {bus.out2_ready, bus.out1_ready};

    // Only ctrl and the registered full flags feed in_ready, never the sink readies.
    assign bus.in_ready = ~full[bus.ctrl];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        demultiplexer_sync_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push   (push[k]),
            .din    (bus.in),
            .rdy    (rdy[k]),
            .dout   (dout[k]),
            .dvalid (dvalid[k]),
            .cnt    (cnt[k]),
            .full   (full[k])
        );
    end

    assign bus.out1       = dout[0];
    assign bus.out1_valid = dvalid[0];
    assign bus.cnt1       = cnt[0];
    assign bus.out2       = dout[1];
    assign bus.out2_valid = dvalid[1];
    assign bus.cnt2       = cnt[1];
endmodule

// File: tb/tb_demultiplexer_sync.sv
// Directed bench for demultiplexer_sync: queue-based channel model checked every
// negedge, plus literal expectations along each scenario.
module tb_demultiplexer_sync;
    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   chk_en = 0;

    demultiplexer_sync_if #(.WIDTH(8), .DEPTH(2)) bus ();

    demultiplexer_sync #(.WIDTH(8), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel model: a word is taken when the chosen queue holds fewer than 2,
    // a pop happens when the queue was non-empty before this edge.
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always @(posedge clk) begin
        bit rdy, p1, p2;
        if (!rst_n) begin
            q1.delete();
            q2.delete();
        end else begin
            rdy = bus.ctrl ? (q2.size() < 2) : (q1.size() < 2);
            p1  = (q1.size() != 0) && bus.out1_ready;
            p2  = (q2.size() != 0) && bus.out2_ready;
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (bus.in_valid && rdy) begin
                if (bus.ctrl) q2.push_back(bus.in);
                else          q1.push_back(bus.in);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_out1_valid", int'(bus.out1_valid), int'(q1.size() != 0));
            chk("m_out1",       int'(bus.out1),       (q1.size() != 0) ? int'(q1[0]) : 0);
            chk("m_cnt1",       int'(bus.cnt1),       q1.size());
            chk("m_out2_valid", int'(bus.out2_valid), int'(q2.size() != 0));
            chk("m_out2",       int'(bus.out2),       (q2.size() != 0) ? int'(q2[0]) : 0);
            chk("m_cnt2",       int'(bus.cnt2),       q2.size());
            chk("m_in_ready",   int'(bus.in_ready),
                bus.ctrl ? int'(q2.size() < 2) : int'(q1.size() < 2));
        end
    end

    initial begin
        logic [7:0] got[$];
        int idx;
        bit pushed;

        rst_n = 1'b0;
        bus.in = '0; bus.in_valid = 1'b0; bus.ctrl = 1'b0;
        bus.out1_ready = 1'b0; bus.out2_ready = 1'b0;

        // 1. reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            bus.in = 8'($urandom); bus.in_valid = 1'($urandom);
            bus.ctrl = 1'($urandom);
            bus.out1_ready = 1'($urandom); bus.out2_ready = 1'($urandom);
            step();
        end
        rst_n = 1'b1; bus.in_valid = 1'b0; chk_en = 1'b1;
        bus.out1_ready = 1'b1; bus.out2_ready = 1'b1;
        chk("rst_out1_valid", int'(bus.out1_valid), 0);
        chk("rst_out2_valid", int'(bus.out2_valid), 0);
        chk("rst_cnt1", int'(bus.cnt1), 0);
        chk("rst_cnt2", int'(bus.cnt2), 0);
        chk("rst_out1", int'(bus.out1), 0);
        chk("rst_out2", int'(bus.out2), 0);
        bus.ctrl = 1'b0; #1 chk("rst_in_ready_c0", int'(bus.in_ready), 1);
        bus.ctrl = 1'b1; #1 chk("rst_in_ready_c1", int'(bus.in_ready), 1);

        // 2. routing
        bus.ctrl = 1'b0; bus.in = 8'hA5; bus.in_valid = 1'b1;
        step();
        chk("rt_out1_valid", int'(bus.out1_valid), 1);
        chk("rt_out1", int'(bus.out1), 'hA5);
        bus.ctrl = 1'b1; bus.in = 8'h3C;
        step();
        bus.in_valid = 1'b0;
        chk("rt_out1_gone", int'(bus.out1_valid), 0);
        chk("rt_out2", int'(bus.out2), 'h3C);
        chk("rt_out2_valid", int'(bus.out2_valid), 1);
        step();
        chk("rt_out2_gone", int'(bus.out2_valid), 0);

        // 3. full channel 1 under backpressure, channel 2 unaffected
        bus.out1_ready = 1'b0; bus.ctrl = 1'b0; bus.in_valid = 1'b1;
        bus.in = 8'h01; step();
        bus.in = 8'h02; step();
        bus.in_valid = 1'b0; #1;
        chk("bp_cnt1_full", int'(bus.cnt1), 2);
        chk("bp_in_ready_c0", int'(bus.in_ready), 0);
        bus.ctrl = 1'b1; #1;
        chk("bp_in_ready_c1", int'(bus.in_ready), 1);
        bus.in = 8'h77; bus.in_valid = 1'b1; step();
        bus.in_valid = 1'b0;
        chk("bp_out2", int'(bus.out2), 'h77);
        bus.out1_ready = 1'b1;
        chk("bp_pop_first", int'(bus.out1), 'h01);
        step();
        chk("bp_pop_second", int'(bus.out1), 'h02);
        bus.ctrl = 1'b0; #1;
        chk("bp_in_ready_back", int'(bus.in_ready), 1);
        step();
        chk("bp_drained", int'(bus.cnt1), 0);

        // 4. simultaneous push and pop on channel 1
        bus.out1_ready = 1'b0; bus.ctrl = 1'b0; bus.in_valid = 1'b1;
        bus.in = 8'h10; step();
        bus.out1_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in = 8'(8'h10 + i); step();
            chk("pp_cnt1", int'(bus.cnt1), 1);
            chk("pp_out1", int'(bus.out1), 'h10 + i);
        end
        bus.out1_ready = 1'b0; bus.in = 8'h20; step();
        chk("pp_cnt1_full", int'(bus.cnt1), 2);
        bus.out1_ready = 1'b1; bus.in = 8'h21; #1;
        chk("pp_blocked_ready", int'(bus.in_ready), 0);
        step();
        bus.in_valid = 1'b0;
        chk("pp_after_cnt1", int'(bus.cnt1), 1);
        chk("pp_after_out1", int'(bus.out1), 'h20);
        chk("pp_after_ready", int'(bus.in_ready), 1);
        step();

        // 5. wrap-around on channel 2 with random sink stalls
        idx = 0;
        bus.ctrl = 1'b1;
        for (int cyc = 0; cyc < 200 && got.size() < 9; cyc++) begin
            bus.in_valid = (idx < 9);
            bus.in = 8'(8'h50 + idx);
            bus.out2_ready = 1'($urandom_range(0, 1));
            #1;
            pushed = bus.in_valid && bus.in_ready;
            if (bus.out2_valid && bus.out2_ready) got.push_back(bus.out2);
            step();
            if (pushed) idx++;
        end
        bus.in_valid = 1'b0; bus.out2_ready = 1'b1;
        chk("wr_count", got.size(), 9);
        for (int i = 0; i < got.size(); i++) chk("wr_word", int'(got[i]), 'h50 + i);

        // 6. reset mid-stream
        bus.out1_ready = 1'b0; bus.out2_ready = 1'b0; bus.in_valid = 1'b1;
        bus.ctrl = 1'b0; bus.in = 8'hA1; step();
        bus.in = 8'hA2; step();
        bus.ctrl = 1'b1; bus.in = 8'hB1; step();
        chk("mr_cnt1_pre", int'(bus.cnt1), 2);
        chk("mr_cnt2_pre", int'(bus.cnt2), 1);
        rst_n = 1'b0; bus.ctrl = 1'b1; bus.in = 8'hEE; step();
        rst_n = 1'b1; bus.in_valid = 1'b0;
        chk("mr_cnt1", int'(bus.cnt1), 0);
        chk("mr_cnt2", int'(bus.cnt2), 0);
        chk("mr_out1_valid", int'(bus.out1_valid), 0);
        chk("mr_out2_valid", int'(bus.out2_valid), 0);
        step();
        chk("mr_not_stored", int'(bus.out2_valid), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
